pkt_deframer: RTL and testbench

Serial-to-parallel packet receiver that sits directly upstream of the packet byte register. It hunts a bit stream for a sync word, captures a PACKET_SIZE-bit payload MSB-first, and checks a trailing 8-bit XOR checksum. On a good packet it presents the payload on `dout` and pulses `pkt_rec` for one cycle, which loads the downstream byte register. Bad or stalled packets are dropped and flagged.

---
 rtl/pkt_deframer.sv | 132 +++++++++++++
 tb/tb_pkt_deframer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_deframer.sv
// Serial bit-stream deframer: hunts for SYNC_WORD, captures a PACKET_SIZE-bit payload
// MSB-first and validates a trailing 8-bit XOR checksum before updating dout.
module pkt_deframer #(
  parameter int          PACKET_SIZE = 64,
  parameter logic [15:0] SYNC_WORD   = 16'hA5C3,
  parameter int          TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  output logic [PACKET_SIZE-1:0] dout,
  output logic                   pkt_rec,
  output logic                   crc_err,
  output logic                   timeout_err,
  output logic                   busy
);

  localparam int BCW    = $clog2(PACKET_SIZE);
  localparam int ICW    = $clog2(TIMEOUT + 1);
  localparam int NBYTES = PACKET_SIZE / 8;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [15:0]            sync_sr;
  logic [PACKET_SIZE-1:0] pay_sr;
  logic [7:0]             chk_sr;
  logic [BCW-1:0]         bit_cnt;
  logic [ICW-1:0]         idle_cnt;

  logic [15:0]            sync_next;
  logic [7:0]             chk_byte;
  logic [7:0]             pay_xor;
  logic                   sync_hit;
  logic                   last_pay;
  logic                   last_chk;
  logic                   expired;
  logic                   good;
  logic                   bad;

  assign sync_next = {sync_sr[14:0], bit_in};
  assign chk_byte  = {chk_sr[6:0], bit_in};

  always_comb begin
    pay_xor = '0;
    for (int i = 0; i < NBYTES; i++) begin
      pay_xor = pay_xor ^ pay_sr[8*i +: 8];
    end
  end

  // Pending bit beats the idle counter: expiry requires a cycle with no bit_valid.
  assign sync_hit = (state == HUNT) && bit_valid && (sync_next == SYNC_WORD);
  assign last_pay = (state == PAYLOAD) && bit_valid && (bit_cnt == BCW'(PACKET_SIZE - 1));
  assign last_chk = (state == CHECK) && bit_valid && (bit_cnt == BCW'(7));
  assign expired  = (state != HUNT) && !bit_valid && (idle_cnt == ICW'(TIMEOUT - 1));
  assign good     = last_chk && (chk_byte == pay_xor);
  assign bad      = last_chk && (chk_byte != pay_xor);

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT: begin
        if (sync_hit) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        if (expired)       state_nxt = HUNT;
        else if (last_pay) state_nxt = CHECK;
      end
      CHECK: begin
        if (expired || last_chk) state_nxt = HUNT;
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      busy        <= 1'b0;
      pkt_rec     <= 1'b0;
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
      dout        <= '0;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt != HUNT);
      pkt_rec     <= good;
      crc_err     <= bad;
      timeout_err <= expired;
      if (good) dout <= pay_sr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_sr  <= '0;
      pay_sr   <= '0;
      chk_sr   <= '0;
      bit_cnt  <= '0;
      idle_cnt <= '0;
    end else begin
      // Clearing on packet exit keeps packet bits out of the next sync search.
      if (good || bad || expired) begin
        sync_sr <= '0;
      end else if (state == HUNT && bit_valid) begin
        sync_sr <= sync_next;
      end

      if (state == PAYLOAD && bit_valid) pay_sr <= {pay_sr[PACKET_SIZE-2:0], bit_in};
      if (state == CHECK && bit_valid)   chk_sr <= chk_byte;

      if (sync_hit || last_pay || last_chk) begin
        bit_cnt <= '0;
      end else if (state != HUNT && bit_valid) begin
        bit_cnt <= bit_cnt + BCW'(1);
      end

      if (state == HUNT || bit_valid || expired) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + ICW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pkt_deframer.sv
// Randomized bench for pkt_deframer, checked every cycle against a bit-list reference model.
module tb_pkt_deframer;

  localparam int          PS      = 64;
  localparam logic [15:0] SYNC    = 16'hA5C3;
  localparam int          TMO     = 255;
  localparam int          FRAMELEN = PS + 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_in;
  logic          bit_valid;
  logic [PS-1:0] dout;
  logic          pkt_rec;
  logic          crc_err;
  logic          timeout_err;
  logic          busy;

  pkt_deframer #(.PACKET_SIZE(PS), .SYNC_WORD(SYNC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .dout(dout),
    .pkt_rec(pkt_rec), .crc_err(crc_err), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rec_cnt = 0;
  int crc_cnt = 0;
  int tmo_cnt = 0;

  // Reference model: frame = list of accepted bits after the sync match.
  bit          m_hunt;
  logic [15:0] m_win;
  bit          m_bits[$];
  int          m_idle;
  logic [PS-1:0] m_dout;
  bit          e_rec, e_crc, e_tmo;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] xsum(input logic [PS-1:0] p);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < PS / 8; i++) x ^= p[8*i +: 8];
    return x;
  endfunction

  task automatic model_reset();
    m_hunt = 1'b1; m_win = '0; m_bits.delete(); m_idle = 0; m_dout = '0;
    e_rec = 0; e_crc = 0; e_tmo = 0;
  endtask

  task automatic model_step(input logic v, input logic b);
    logic [PS-1:0] p;
    logic [7:0]    ck;
    e_rec = 0; e_crc = 0; e_tmo = 0;
    if (m_hunt) begin
      if (v) begin
        m_win = {m_win[14:0], b};
        if (m_win == SYNC) begin
          m_hunt = 1'b0;
          m_bits.delete();
          m_idle = 0;
        end
      end
    end else if (v) begin
      m_idle = 0;
      m_bits.push_back(b);
      if (m_bits.size() == FRAMELEN) begin
        p = '0; ck = '0;
        for (int i = 0; i < PS; i++) p = {p[PS-2:0], m_bits[i]};
        for (int i = PS; i < FRAMELEN; i++) ck = {ck[6:0], m_bits[i]};
        if (ck == xsum(p)) begin
          m_dout = p;
          e_rec = 1;
        end else begin
          e_crc = 1;
        end
        m_hunt = 1'b1;
        m_win  = '0;
      end
    end else begin
      m_idle++;
      if (m_idle == TMO) begin
        e_tmo  = 1;
        m_hunt = 1'b1;
        m_win  = '0;
      end
    end
  endtask

  task automatic cycle(input logic v, input logic b);
    bit_valid = v;
    bit_in    = b;
    @(posedge clk);
    model_step(v, b);
    #1;
    check_val("pkt_rec", 64'(pkt_rec), 64'(e_rec));
    check_val("crc_err", 64'(crc_err), 64'(e_crc));
    check_val("timeout_err", 64'(timeout_err), 64'(e_tmo));
    check_val("busy", 64'(busy), 64'(!m_hunt));
    check_val("dout", dout, m_dout);
    if (pkt_rec)     rec_cnt++;
    if (crc_err)     crc_cnt++;
    if (timeout_err) tmo_cnt++;
  endtask

  task automatic send_bit(input logic b, input int maxgap);
    repeat ($urandom_range(0, maxgap)) cycle(1'b0, 1'($urandom_range(0, 1)));
    cycle(1'b1, b);
  endtask

  // Sends sync + payload + checksum (first nbits only), stalling stall_len idle cycles
  // before bit index stall_at.
  task automatic send_frame(input logic [PS-1:0] p, input logic [7:0] ck, input int maxgap,
                            input int stall_at, input int stall_len, input int nbits);
    logic [FRAMELEN+15:0] f;
    f = {SYNC, p, ck};
    for (int i = 0; i <= nbits; i++) begin
      if (i == stall_at) repeat (stall_len) cycle(1'b0, 1'($urandom_range(0, 1)));
      if (i < nbits) send_bit(f[FRAMELEN+15-i], maxgap);
    end
  endtask

  task automatic clear_counts();
    rec_cnt = 0; crc_cnt = 0; tmo_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'($urandom_range(0, 1)));
  endtask

  localparam logic [PS-1:0] P1 = 64'h1122334455667788;
  localparam logic [PS-1:0] P2 = 64'hA5C3A5C312345678;

  initial begin
    logic [PS-1:0] p;
    logic [7:0]    ck;
    logic [12:0]   prefix;
    int            stall_at;

    rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_val("rst_dout", dout, 64'h0);
    check_val("rst_pkt_rec", 64'(pkt_rec), 64'h0);
    check_val("rst_crc_err", 64'(crc_err), 64'h0);
    check_val("rst_timeout_err", 64'(timeout_err), 64'h0);
    check_val("rst_busy", 64'(busy), 64'h0);
    #2 rst = 1'b0;
    idle(3);

    // Bad checksum straight after reset leaves dout at 0.
    clear_counts();
    send_frame(P1, 8'h89, 0, -1, 0, FRAMELEN + 16);
    idle(2);
    check_val("bad0_crc_cnt", 64'(crc_cnt), 64'd1);
    check_val("bad0_rec_cnt", 64'(rec_cnt), 64'd0);
    check_val("bad0_dout", dout, 64'h0);

    // Good packet, continuous bits.
    clear_counts();
    send_frame(P1, 8'h88, 0, -1, 0, FRAMELEN + 16);
    idle(2);
    check_val("good_rec_cnt", 64'(rec_cnt), 64'd1);
    check_val("good_dout", dout, P1);
    check_val("good_busy", 64'(busy), 64'h0);

    // Bad checksum keeps the previous good payload.
    clear_counts();
    send_frame(64'h0102030405060708, 8'h00, 1, -1, 0, FRAMELEN + 16);
    idle(2);
    check_val("bad1_crc_cnt", 64'(crc_cnt), 64'd1);
    check_val("bad1_dout", dout, P1);

    // Timeout after 20 payload bits, then a good frame.
    clear_counts();
    send_frame(P2, xsum(P2), 0, 36, TMO, 36);
    check_val("tmo_cnt", 64'(tmo_cnt), 64'd1);
    check_val("tmo_busy", 64'(busy), 64'h0);
    send_frame(P2, xsum(P2), 0, -1, 0, FRAMELEN + 16);
    idle(2);
    check_val("tmo_then_rec", 64'(rec_cnt), 64'd1);
    check_val("tmo_then_dout", dout, P2);

    // One cycle short of the timeout mid-payload.
    clear_counts();
    send_frame(P1, xsum(P1), 0, 46, TMO - 1, FRAMELEN + 16);
    idle(2);
    check_val("gap_tmo_cnt", 64'(tmo_cnt), 64'd0);
    check_val("gap_rec_cnt", 64'(rec_cnt), 64'd1);
    check_val("gap_dout", dout, P1);

    // Partial sync prefix, then a frame whose payload itself contains the sync word.
    clear_counts();
    prefix = 13'b1010010111000;
    for (int i = 12; i >= 0; i--) cycle(1'b1, prefix[i]);
    send_frame(P2, xsum(P2), 0, -1, 0, FRAMELEN + 16);
    idle(3);
    check_val("sync_rec_cnt", 64'(rec_cnt), 64'd1);
    check_val("sync_crc_cnt", 64'(crc_cnt), 64'd0);
    check_val("sync_dout", dout, P2);

    // Asynchronous reset after 30 payload bits.
    send_frame(P1, xsum(P1), 0, -1, 0, 46);
    bit_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_val("arst_dout", dout, 64'h0);
    check_val("arst_busy", 64'(busy), 64'h0);
    check_val("arst_pkt_rec", 64'(pkt_rec), 64'h0);
    check_val("arst_crc_err", 64'(crc_err), 64'h0);
    check_val("arst_timeout_err", 64'(timeout_err), 64'h0);
    model_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    clear_counts();
    send_frame(P1, xsum(P1), 0, -1, 0, FRAMELEN + 16);
    send_frame(P2, xsum(P2), 0, -1, 0, FRAMELEN + 16);
    idle(2);
    check_val("b2b_rec_cnt", 64'(rec_cnt), 64'd2);
    check_val("b2b_dout", dout, P2);
    check_val("b2b_err_cnt", 64'(crc_cnt + tmo_cnt), 64'd0);

    // Random frames, gaps, bad checksums, stalls around the timeout and line noise.
    for (int n = 0; n < 30; n++) begin
      p  = {$urandom, $urandom};
      ck = xsum(p);
      if ($urandom_range(0, 3) == 0) ck ^= 8'($urandom_range(1, 255));
      stall_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(17, FRAMELEN + 15)) : -1;
      send_frame(p, ck, $urandom_range(0, 3), stall_at, $urandom_range(TMO - 3, TMO + 3),
                 FRAMELEN + 16);
      repeat ($urandom_range(0, 12)) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle(TMO + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
